// File: rtl/pdpu_pkg.sv
// Shared helpers for the PDPU max-exponent search tree: index width, the
// most-negative exponent used for masked lanes, and per-level entry counts.
package pdpu_pkg;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic longint exp_sentinel(input int width);
        return -(longint'(1) << width);
    endfunction

    // Entries left after lvl rounds of pairwise reduction; an odd entry passes through.
    function automatic int level_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/pdpu_max_exp_node.sv
// One compare node of the max-exponent tree: a valid lane beats an invalid one,
// the larger signed exponent wins, and ties go to the lower lane index.
module pdpu_max_exp_node #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic signed [WIDTH:0]  a_exp,
    input  logic        [IDXW-1:0] a_idx,
    input  logic                   a_vld,
    input  logic signed [WIDTH:0]  b_exp,
    input  logic        [IDXW-1:0] b_idx,
    input  logic                   b_vld,
    output logic signed [WIDTH:0]  y_exp,
    output logic        [IDXW-1:0] y_idx,
    output logic                   y_vld
);

    logic take_b;

    always_comb begin
        take_b = 1'b0;
        if (a_vld != b_vld) begin
            take_b = b_vld;
        end else if (a_vld) begin
            if (b_exp > a_exp) begin
                take_b = 1'b1;
            end else if (b_exp == a_exp) begin
                take_b = (b_idx < a_idx);
            end
        end else begin
            // Both masked: keep the lower index so an all-masked item reports lane 0.
            take_b = (b_idx < a_idx);
        end
    end

    assign y_exp = take_b ? b_exp : a_exp;
    assign y_idx = take_b ? b_idx : a_idx;
    assign y_vld = a_vld | b_vld;

endmodule

// File: rtl/pdpu_max_exp_tree_pipe.sv
// Pipelined, stallable max-exponent search over N masked signed lanes, with a
// register after every REG_EVERY comparator levels and one global advance enable.
module pdpu_max_exp_tree_pipe
    import pdpu_pkg::*;
#(
    parameter int N         = 8,
    parameter int WIDTH     = 8,
    parameter int REG_EVERY = 1,
    localparam int IDXW     = idx_width(N)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [N-1:0][WIDTH:0]       exp_i,
    input  logic [N-1:0]                mask_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [WIDTH:0]       max_exp_o,
    output logic        [IDXW-1:0]      max_idx_o,
    output logic                        all_masked_o
);

    localparam int     LEVELS   = $clog2(N);
    localparam int     LV       = (LEVELS < 1) ? 1 : LEVELS;
    localparam int     STAGES   = (LV + REG_EVERY - 1) / REG_EVERY;
    localparam longint SENT_L   = exp_sentinel(WIDTH);
    localparam logic signed [WIDTH:0] SENTINEL = SENT_L[WIDTH:0];

    logic [STAGES-1:0] vld_p;
    logic              adv;

    assign out_valid_o = vld_p[STAGES-1];
    assign adv         = ~out_valid_o | out_ready_i;
    assign in_ready_o  = adv;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p <= '0;
        end else if (flush_i) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p[0] <= in_valid_i;
            for (int s = 1; s < STAGES; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int CI     = level_count(N, l);
        localparam int CO     = level_count(N, l + 1);
        localparam bit IS_REG = ((l + 1) % REG_EVERY == 0);

        logic signed [WIDTH:0]  in_exp [CI];
        logic        [IDXW-1:0] in_idx [CI];
        logic                   in_vld [CI];
        logic signed [WIDTH:0]  nd_exp [CO];
        logic        [IDXW-1:0] nd_idx [CO];
        logic                   nd_vld [CO];
        logic signed [WIDTH:0]  exp_p  [CO];
        logic        [IDXW-1:0] idx_p  [CO];
        logic                   lv_p   [CO];

        if (l == 0) begin : g_src
            for (genvar k = 0; k < N; k++) begin : g_lane
                assign in_exp[k] = mask_i[k] ? $signed(exp_i[k]) : SENTINEL;
                assign in_idx[k] = IDXW'(k);
                assign in_vld[k] = mask_i[k];
            end
        end else begin : g_chain
            assign in_exp = g_lvl[l-1].exp_p;
            assign in_idx = g_lvl[l-1].idx_p;
            assign in_vld = g_lvl[l-1].lv_p;
        end

        for (genvar j = 0; j < CO; j++) begin : g_node
            if (2 * j + 1 < CI) begin : g_cmp
                pdpu_max_exp_node #(
                    .WIDTH (WIDTH),
                    .IDXW  (IDXW)
                ) u_node (
                    .a_exp (in_exp[2*j]),
                    .a_idx (in_idx[2*j]),
                    .a_vld (in_vld[2*j]),
                    .b_exp (in_exp[2*j+1]),
                    .b_idx (in_idx[2*j+1]),
                    .b_vld (in_vld[2*j+1]),
                    .y_exp (nd_exp[j]),
                    .y_idx (nd_idx[j]),
                    .y_vld (nd_vld[j])
                );
            end else begin : g_pass
                assign nd_exp[j] = in_exp[2*j];
                assign nd_idx[j] = in_idx[2*j];
                assign nd_vld[j] = in_vld[2*j];
            end
        end

        if (l == LV - 1) begin : g_out_reg
            // Final stage: lane-valid resets high so all_masked_o reads 0 out of reset.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    exp_p[0] <= '0;
                    idx_p[0] <= '0;
                    lv_p[0]  <= 1'b1;
                end else if (adv) begin
                    exp_p[0] <= nd_exp[0];
                    idx_p[0] <= nd_idx[0];
                    lv_p[0]  <= nd_vld[0];
                end
            end
        end else if (IS_REG) begin : g_mid_reg
            // Intermediate stage boundary.
            always_ff @(posedge clk_i) begin
                if (adv) begin
                    exp_p <= nd_exp;
                    idx_p <= nd_idx;
                    lv_p  <= nd_vld;
                end
            end
        end else begin : g_comb
            assign exp_p = nd_exp;
            assign idx_p = nd_idx;
            assign lv_p  = nd_vld;
        end
    end

    assign max_exp_o    = g_lvl[LV-1].exp_p[0];
    assign max_idx_o    = g_lvl[LV-1].idx_p[0];
    assign all_masked_o = ~g_lvl[LV-1].lv_p[0];

endmodule

// File: tb/tb_pdpu_max_exp_tree_pipe.sv
// Directed bench for the max-exponent tree: an N=8 instance for latency, ties,
// masking, streaming, stall and flush, and an N=5/REG_EVERY=2 instance for reset.
module tb_pdpu_max_exp_tree_pipe;

    typedef logic [7:0][8:0] vec_t;
    typedef struct {
        int mx;
        int ix;
        int am;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, am_a;
    vec_t              exp_a;
    logic [7:0]        mask_a;
    logic signed [8:0] max_a;
    logic [2:0]        idx_a;

    logic              flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, am_b;
    logic [4:0][8:0]   exp_b;
    logic [4:0]        mask_b;
    logic signed [8:0] max_b;
    logic [2:0]        idx_b;

    int   checks = 0;
    int   errors = 0;
    int   got    = 0;
    res_t sb[$];

    pdpu_max_exp_tree_pipe #(.N(8), .WIDTH(8), .REG_EVERY(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a), .in_valid_i(in_valid_a),
        .in_ready_o(in_ready_a), .exp_i(exp_a), .mask_i(mask_a), .out_valid_o(out_valid_a),
        .out_ready_i(out_ready_a), .max_exp_o(max_a), .max_idx_o(idx_a), .all_masked_o(am_a)
    );

    pdpu_max_exp_tree_pipe #(.N(5), .WIDTH(8), .REG_EVERY(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b), .in_valid_i(in_valid_b),
        .in_ready_o(in_ready_b), .exp_i(exp_b), .mask_i(mask_b), .out_valid_o(out_valid_b),
        .out_ready_i(out_ready_b), .max_exp_o(max_b), .max_idx_o(idx_b), .all_masked_o(am_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    // Reference: first unmasked lane holding the largest signed value.
    function automatic res_t ref_max(input vec_t e, input logic [7:0] m);
        res_t r;
        r.mx = -256;
        r.ix = 0;
        r.am = 1;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && (r.am == 1 || $signed(e[i]) > r.mx)) begin
                r.mx = $signed(e[i]);
                r.ix = i;
                r.am = 0;
            end
        end
        return r;
    endfunction

    function automatic vec_t gen_vec(input int i);
        vec_t v;
        for (int k = 0; k < 8; k++) begin
            v[k] = 9'((i * 97 + k * 53 + k * k * 11) % 512);
        end
        return v;
    endfunction

    function automatic logic [7:0] gen_mask(input int i);
        return (i % 5 == 4) ? 8'h00 : 8'((i * 73) ^ 8'hC3);
    endfunction

    // One clock of DUT A with scoreboard push on accept and pop on output transfer.
    task automatic step_a(input logic v, input vec_t e, input logic [7:0] m, input logic rdy,
                          output logic acc);
        res_t x;
        in_valid_a  = v;
        exp_a       = e;
        mask_a      = m;
        out_ready_a = rdy;
        @(negedge clk);
        acc = v & in_ready_a;
        if (acc) sb.push_back(ref_max(e, m));
        if (out_valid_a && out_ready_a) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", out_valid_a, 0);
            end else begin
                x = sb.pop_front();
                chk("sb_max", max_a, x.mx);
                chk("sb_idx", idx_a, x.ix);
                chk("sb_all_masked", am_a, x.am);
                got++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       t1;
        vec_t       zero_v;
        logic       acc;
        int         vi;
        logic [4:0][8:0] t6;

        zero_v = '0;
        t1[0] = 9'(3);  t1[1] = 9'(-5); t1[2] = 9'(7); t1[3] = 9'(0);
        t1[4] = 9'(7);  t1[5] = 9'(-1); t1[6] = 9'(2); t1[7] = 9'(1);
        t6[0] = 9'(-2); t6[1] = 9'(-2); t6[2] = 9'(-9); t6[3] = 9'(-2); t6[4] = 9'(-3);

        rst_n = 1'b0;
        flush_a = 1'b0; in_valid_a = 1'b0; exp_a = '0; mask_a = '0; out_ready_a = 1'b1;
        flush_b = 1'b0; in_valid_b = 1'b0; exp_b = '0; mask_b = '0; out_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_max", max_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_all_masked", am_a, 0);
        chk("rst_b_out_valid", out_valid_b, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready_a, 1);
        @(posedge clk);
        #1;

        // Test 1: latency 3 and tie on lanes 2/4 goes to lane 2.
        in_valid_a = 1'b1; exp_a = t1; mask_a = 8'hFF;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        chk("t1_lat1", out_valid_a, 0);
        @(posedge clk); #1;
        chk("t1_lat2", out_valid_a, 0);
        @(posedge clk); #1;
        chk("t1_valid", out_valid_a, 1);
        chk("t1_max", max_a, 7);
        chk("t1_idx", idx_a, 2);
        chk("t1_all_masked", am_a, 0);

        // Test 2: lane 2 masked, then everything masked.
        in_valid_a = 1'b1; mask_a = 8'hFB;
        @(posedge clk); #1;
        mask_a = 8'h00;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(posedge clk); #1;
        chk("t2a_valid", out_valid_a, 1);
        chk("t2a_max", max_a, 7);
        chk("t2a_idx", idx_a, 4);
        chk("t2a_all_masked", am_a, 0);
        @(posedge clk); #1;
        chk("t2b_valid", out_valid_a, 1);
        chk("t2b_max", max_a, -256);
        chk("t2b_idx", idx_a, 0);
        chk("t2b_all_masked", am_a, 1);
        @(posedge clk); #1;
        chk("t2_idle", out_valid_a, 0);

        // Test 3: eight back-to-back items emerge on eight consecutive cycles.
        got = 0;
        for (int i = 0; i < 8; i++) step_a(1'b1, gen_vec(i), gen_mask(i), 1'b1, acc);
        for (int i = 0; i < 3; i++) step_a(1'b0, zero_v, 8'h00, 1'b1, acc);
        chk("t3_count", got, 8);
        chk("t3_sb_empty", sb.size(), 0);
        chk("t3_idle", out_valid_a, 0);

        // Test 4: fill with downstream stalled, hold 5 cycles, then release.
        got = 0;
        vi  = 8;
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, gen_vec(vi), gen_mask(vi), 1'b0, acc);
            if (acc) vi++;
        end
        chk("t4_full_valid", out_valid_a, 1);
        chk("t4_full_ready", in_ready_a, 0);
        for (int i = 0; i < 5; i++) begin
            step_a(1'b1, gen_vec(vi), gen_mask(vi), 1'b0, acc);
            if (acc) vi++;
            chk("t4_stall_ready", in_ready_a, 0);
            chk("t4_stall_valid", out_valid_a, 1);
            chk("t4_stall_max", max_a, sb[0].mx);
            chk("t4_stall_idx", idx_a, sb[0].ix);
        end
        while (vi < 14) begin
            step_a(1'b1, gen_vec(vi), gen_mask(vi), 1'b1, acc);
            if (acc) vi++;
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) step_a(1'b0, zero_v, 8'h00, 1'b1, acc);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_count", got, 6);
        chk("t4_idle", out_valid_a, 0);

        // Test 5: flush with three items in flight; a following item still has latency 3.
        out_ready_a = 1'b1;
        in_valid_a = 1'b1; exp_a = gen_vec(20); mask_a = 8'hFF;
        @(posedge clk); #1;
        exp_a = gen_vec(21);
        @(posedge clk); #1;
        exp_a = gen_vec(22); flush_a = 1'b1;
        chk("t5_flush_ready", in_ready_a, 1);
        @(posedge clk); #1;
        flush_a = 1'b0;
        chk("t5_after_flush", out_valid_a, 0);
        exp_a = t1; mask_a = 8'h03;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        chk("t5_gap1", out_valid_a, 0);
        @(posedge clk); #1;
        chk("t5_gap2", out_valid_a, 0);
        @(posedge clk); #1;
        chk("t5_next_valid", out_valid_a, 1);
        chk("t5_next_max", max_a, 3);
        chk("t5_next_idx", idx_a, 0);
        out_ready_a = 1'b0; flush_a = 1'b1;
        @(posedge clk); #1;
        chk("t5_flush_over_stall", out_valid_a, 0);
        flush_a = 1'b0; out_ready_a = 1'b1;

        // Test 6: N=5, REG_EVERY=2 (latency 2), then reset mid-stream.
        in_valid_b = 1'b1; exp_b = t6; mask_b = 5'h1F;
        @(posedge clk); #1;
        chk("t6_lat1", out_valid_b, 0);
        mask_b = 5'h16;
        @(posedge clk); #1;
        chk("t6a_valid", out_valid_b, 1);
        chk("t6a_max", max_b, -2);
        chk("t6a_idx", idx_b, 0);
        chk("t6a_all_masked", am_b, 0);
        mask_b = 5'h1F;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        chk("t6b_max", max_b, -2);
        chk("t6b_idx", idx_b, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid_b, 0);
        chk("t6_rst_max", max_b, 0);
        chk("t6_rst_idx", idx_b, 0);
        chk("t6_rst_all_masked", am_b, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_rst_ready", in_ready_b, 1);
        chk("t6_post_rst1", out_valid_b, 0);
        @(posedge clk); #1;
        chk("t6_post_rst2", out_valid_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
